data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
- Parametrised, byte-addressable, little-endian data memory for the RISC-V pipeline's MEM stage. Successor to the flat word memory.
- Adds RV32I load/store sizing (byte, half, word) with sign or zero extension and per-byte write enables.
- Adds misalignment and range fault detection.
- Adds a valid/ready request handshake with configurable wait states, so the pipeline can be stalled against slower memory.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 for RV32, and elaboration fails otherwise.
- DEPTH, 64, memory depth in 32-bit words.
- WAIT_STATES, 0, extra busy cycles per access, legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access faulted; qualified by rsp_valid.

Behaviour:
- Reset: asynchronous, active-high. Clock is clk; the port is named reset.
  - On reset: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, wait counter = 0.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. Accept on req_valid & req_ready at a rising edge; latch write, funct3, addr, wdata.
  - After accept: go to WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES-1), else go to RESP.
  - WAIT: req_ready = 0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, req_ready = 0, then return to IDLE.
  - No back-to-back acceptance. Issue rate is one request per WAIT_STATES + 2 cycles.
- Latency: rsp_valid rises WAIT_STATES + 1 cycles after the accept edge.
- Fault detection, evaluated on the latched request:
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr >= DEPTH*4.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - On fault: no memory write occurs, rsp_rdata = 0, rsp_fault = 1.
- Store: committed to memory on the edge entering RESP, only when no fault.
  - Word index = addr[ADDR_W-1:2].
  - Byte enables from funct3 and addr[1:0]: SB writes wdata[7:0] to lane addr[1:0]; SH writes wdata[15:0] to lanes addr[1]*2 and +1; SW writes all four lanes.
  - Unselected bytes are unchanged.
- Load: word read on the edge entering RESP, then lane-selected and extended.
  - LB/LH: sign-extend. LBU/LHU: zero-extend.
  - Result registered onto rsp_rdata.
  - rsp_rdata and rsp_fault hold their values until the next response.
  - For stores, rsp_rdata = 0.
- req_* inputs are ignored outside IDLE. A change during WAIT has no effect.
- Reset mid-operation (WAIT or RESP): the access is aborted, no write is performed, and no rsp_valid is produced.
- Address arithmetic: range compare at full ADDR_W width, with no truncation before the compare. An address at or above DEPTH*4 must fault and must not alias onto a low word.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum: dmem_state_t.
  - Function for byte-enable generation.
  - Function for load extension.
- Sub-module dmem_byte_array: DEPTH x 32 storage with 4-bit byte write enable and combinational read. It is the only storage instance.
- FSM, fault checker and lane steering live in data_memory_lsu.

Test Plan:
- WAIT_STATES=0. SW addr 0x08, wdata 0xDEADBEEF -> rsp_valid 1 cycle after accept, fault 0. Then LW 0x08 -> rsp_rdata 0xDEADBEEF.
- After word 0x08 = 0xDEADBEEF:
  - SB 0x09, wdata 0x000000A5 -> LW 0x08 returns 0xDEADA5EF.
  - LB 0x09 -> 0xFFFFFFA5.
  - LBU 0x09 -> 0x000000A5.
  - LH 0x0A -> 0xFFFFDEAD.
  - LHU 0x0A -> 0x0000DEAD.
- Faults:
  - LW 0x06 -> fault 1, rdata 0.
  - SH 0x05 -> fault 1, memory unchanged.
  - LW 0x100 with DEPTH=64 -> fault 1, word 0 not read.
  - funct3 011 load -> fault 1.
- WAIT_STATES=3:
  - Accept at cycle 0 -> req_ready 0 in cycles 1-4, rsp_valid at cycle 4, req_ready 1 at cycle 5.
  - req_valid held high with changing addr during WAIT -> only the first request is served.
- SW 0x10 = 0x12345678 accepted with WAIT_STATES=3, reset asserted in the cycle after accept -> rsp_valid never asserts, all outputs return to reset values. A subsequent LW 0x10 returns the prior contents, not 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 encodings, FSM states,
// byte-enable generation and load-data extension.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } dmem_state_t;

    function automatic logic [3:0] dmem_byte_en(input logic [2:0] funct3,
                                                input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            F3_B:    be = 4'b0001 << offset;
            F3_H:    be = offset[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] dmem_load_ext(input logic [2:0]  funct3,
                                                  input logic [31:0] word,
                                                  input logic [1:0]  offset);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[8*offset +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_BU:   res = {24'h000000, b};
            F3_HU:   res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module dmem_byte_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable little-endian data memory with RV32I load/store sizing, fault detection
// and a valid/ready request handshake with configurable wait states.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("data_memory_lsu: DATA_W must be 32");
    end
    if (WAIT_STATES > 15) begin : g_wait_check
        $error("data_memory_lsu: WAIT_STATES must be 0..15");
    end

    localparam int unsigned      IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W+1:0] AddrLimit = (ADDR_W + 2)'(DEPTH) << 2;
    localparam logic [3:0]       WaitLoad  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q;

    logic              in_idle, accept, enter_resp;
    logic              cur_write;
    logic [2:0]        cur_funct3;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              misaligned, out_of_range, illegal, fault;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata, mem_rdata;

    // With zero wait states the access completes on the accept edge itself, so the
    // datapath works from the live request in IDLE and from the latched copy otherwise.
    always_comb begin
        in_idle    = (state_q == StIdle);
        cur_write  = in_idle ? req_write  : write_q;
        cur_funct3 = in_idle ? req_funct3 : funct3_q;
        cur_addr   = in_idle ? req_addr   : addr_q;
        cur_wdata  = in_idle ? req_wdata  : wdata_q;

        misaligned = (((cur_funct3 == F3_H) || (cur_funct3 == F3_HU)) && cur_addr[0])
                   || ((cur_funct3 == F3_W) && (cur_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, cur_addr} >= AddrLimit);
        if (cur_write) begin
            illegal = !(cur_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(cur_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        fault = misaligned || out_of_range || illegal;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        enter_resp = 1'b1;
                        state_d    = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    enter_resp = 1'b1;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_we = 4'b0000;
        if (enter_resp && cur_write && !fault && !reset) begin
            mem_we = dmem_byte_en(cur_funct3, cur_addr[1:0]);
        end
        case (cur_funct3)
            F3_B:    mem_wdata = {4{cur_wdata[7:0]}};
            F3_H:    mem_wdata = {2{cur_wdata[15:0]}};
            default: mem_wdata = cur_wdata;
        endcase
        rdata_d = (cur_write || fault) ? '0 : dmem_load_ext(cur_funct3, mem_rdata, cur_addr[1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                fault_q <= fault;
            end
        end
    end

    dmem_byte_array #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .idx_i   (cur_addr[IdxW+1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench: two instances (0 and 3 wait states) checked against a byte-level
// reference memory; a negedge monitor pops expected responses as they appear.
module tb_data_memory_lsu;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_fault  [2];

    always #5 clk = ~clk;

    data_memory_lsu #(
        .ADDR_W (32), .DATA_W (32), .DEPTH (64), .WAIT_STATES (0)
    ) u_dut0 (
        .clk (clk), .reset (reset[0]),
        .req_valid (req_valid[0]), .req_ready (req_ready[0]), .req_write (req_write[0]),
        .req_funct3 (req_funct3[0]), .req_addr (req_addr[0]), .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]), .rsp_rdata (rsp_rdata[0]), .rsp_fault (rsp_fault[0])
    );

    data_memory_lsu #(
        .ADDR_W (32), .DATA_W (32), .DEPTH (64), .WAIT_STATES (3)
    ) u_dut3 (
        .clk (clk), .reset (reset[1]),
        .req_valid (req_valid[1]), .req_ready (req_ready[1]), .req_write (req_write[1]),
        .req_funct3 (req_funct3[1]), .req_addr (req_addr[1]), .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]), .rsp_rdata (rsp_rdata[1]), .rsp_fault (rsp_fault[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        string       tag;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [7:0]  mm [2][256];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-granular memory, size = 1 << funct3[1:0], fault rules applied directly.
    function automatic exp_t model(input int d, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input string tag);
        exp_t        e;
        int          size;
        bit          legal;
        logic [31:0] v;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        e.tag   = tag;
        e.rdata = 32'h0;
        e.fault = !legal || (addr % size != 0) || (addr >= 32'd256);
        if (!e.fault && wr) begin
            for (int i = 0; i < size; i++) mm[d][int'(addr) + i] = wd[8*i +: 8];
        end
        if (!e.fault && !wr) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v |= 32'(mm[d][int'(addr) + i]) << (8 * i);
            if (!f3[2] && size < 4 && v[8*size-1]) v |= 32'hFFFF_FFFF << (8 * size);
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic mon_pop(input int d);
        exp_t e;
        if (q_size(d) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected no response", d);
        end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("dut%0d %s rdata", d, e.tag), rsp_rdata[d], e.rdata);
            check($sformatf("dut%0d %s fault", d, e.tag), 32'(rsp_fault[d]), 32'(e.fault));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) mon_pop(d);
        end
    end

    task automatic wait_ready(input int d);
        int guard = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready[d] !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout dut%0d: got req_ready=%b expected 1", d, req_ready[d]);
        end
    endtask

    task automatic issue(input int d, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
        wait_ready(d);
        push_exp(d, model(d, wr, f3, addr, wd, tag));
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int guard = 0;
        while (q_size(d) != 0 && guard < 60) begin
            @(posedge clk);
            guard++;
        end
        if (q_size(d) != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", d, q_size(d));
            if (d == 0) exp_q0.delete();
            else exp_q1.delete();
        end
    endtask

    // Holds req_valid high through the busy window with a changing store request;
    // only the first (a load) may be served.
    task automatic timing(input int d, input int ws);
        wait_ready(d);
        push_exp(d, model(d, 1'b0, 3'b010, 32'h08, 32'h0, "timing_lw"));
        req_valid[d]  = 1'b1;
        req_write[d]  = 1'b0;
        req_funct3[d] = 3'b010;
        req_addr[d]   = 32'h08;
        @(posedge clk);
        for (int k = 1; k <= ws + 2; k++) begin
            #1;
            if (k <= ws) begin
                req_write[d]  = 1'b1;
                req_funct3[d] = 3'b010;
                req_addr[d]   = $urandom_range(0, 63) * 4;
                req_wdata[d]  = $urandom;
            end
            @(negedge clk);
            check($sformatf("dut%0d timing ready c%0d", d, k), 32'(req_ready[d]),
                  32'(k == ws + 2));
            check($sformatf("dut%0d timing valid c%0d", d, k), 32'(rsp_valid[d]),
                  32'(k == ws + 1));
            if (k == ws + 1) req_valid[d] = 1'b0;
            @(posedge clk);
        end
        drain(d);
    endtask

    task automatic directed(input int d);
        issue(d, 1, 3'b010, 32'h08, 32'hDEADBEEF, "sw_08");
        issue(d, 0, 3'b010, 32'h08, 32'h0, "lw_08");
        issue(d, 1, 3'b000, 32'h09, 32'h000000A5, "sb_09");
        issue(d, 0, 3'b010, 32'h08, 32'h0, "lw_08_after_sb");
        issue(d, 0, 3'b000, 32'h09, 32'h0, "lb_09");
        issue(d, 0, 3'b100, 32'h09, 32'h0, "lbu_09");
        issue(d, 0, 3'b001, 32'h0A, 32'h0, "lh_0a");
        issue(d, 0, 3'b101, 32'h0A, 32'h0, "lhu_0a");
        issue(d, 0, 3'b010, 32'h06, 32'h0, "lw_06_misal");
        issue(d, 1, 3'b001, 32'h05, $urandom, "sh_05_misal");
        issue(d, 0, 3'b010, 32'h04, 32'h0, "lw_04_unchanged");
        issue(d, 0, 3'b010, 32'h100, 32'h0, "lw_100_range");
        issue(d, 0, 3'b010, 32'h108, 32'h0, "lw_108_alias");
        issue(d, 0, 3'b010, 32'h8000_0008, 32'h0, "lw_hi_alias");
        issue(d, 1, 3'b010, 32'hFC, 32'hCAFEF00D, "sw_last");
        issue(d, 0, 3'b010, 32'hFC, 32'h0, "lw_last");
        issue(d, 1, 3'b000, 32'h100, 32'h11, "sb_100_range");
        issue(d, 0, 3'b010, 32'h00, 32'h0, "lw_00_after_range");
        issue(d, 0, 3'b011, 32'h00, 32'h0, "ld_f3_011");
        issue(d, 0, 3'b110, 32'h00, 32'h0, "ld_f3_110");
        issue(d, 1, 3'b100, 32'h0C, 32'h55, "st_f3_100");
        issue(d, 0, 3'b010, 32'h0C, 32'h0, "lw_0c_after_bad_st");
        drain(d);
    endtask

    initial begin
        logic [2:0]  legal_f3 [5];
        logic [31:0] prior;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        wr;
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int d = 0; d < 2; d++) begin
            reset[d]      = 1'b1;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_funct3[d] = 3'b000;
            req_addr[d]   = 32'h0;
            req_wdata[d]  = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("dut%0d reset valid", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("dut%0d reset rdata", d), rsp_rdata[d], 32'd0);
            check($sformatf("dut%0d reset fault", d), 32'(rsp_fault[d]), 32'd0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) issue(d, 1, 3'b010, w * 4, $urandom, "init_sw");
            drain(d);
            directed(d);
        end

        timing(0, 0);
        timing(1, 3);

        // Reset while a store sits in WAIT: no write, no response, outputs back to reset.
        prior = $urandom | 32'h1;
        issue(1, 1, 3'b010, 32'h10, prior, "sw_10_prior");
        issue(1, 0, 3'b010, 32'h10, 32'h0, "lw_10_prior");
        drain(1);
        wait_ready(1);
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b1;
        req_funct3[1] = 3'b010;
        req_addr[1]   = 32'h10;
        req_wdata[1]  = 32'h12345678;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        reset[1] = 1'b1;
        #1;
        check("dut1 midreset ready", 32'(req_ready[1]), 32'd1);
        check("dut1 midreset valid", 32'(rsp_valid[1]), 32'd0);
        check("dut1 midreset rdata", rsp_rdata[1], 32'd0);
        check("dut1 midreset fault", 32'(rsp_fault[1]), 32'd0);
        @(negedge clk);
        reset[1] = 1'b0;
        repeat (8) @(negedge clk);
        issue(1, 0, 3'b010, 32'h10, 32'h0, "lw_10_after_abort");
        drain(1);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                wr = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) < 6) f3 = legal_f3[$urandom_range(0, 4)];
                else f3 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 9))
                    8:       addr = 32'd256 + $urandom_range(0, 255);
                    9:       addr = $urandom;
                    default: addr = $urandom_range(0, 255);
                endcase
                if ($urandom_range(0, 3) != 0) begin
                    if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                    if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
                end
                issue(d, wr, f3, addr, $urandom, "random");
            end
            drain(d);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
